// File: rtl/asic_iopwrseq.sv
// Padring IO power sequencer: orders supply settle, isolation release and output enable on the control ring.
// Latency: all outputs registered on the state edge; iopg reaches the decision logic after a 2-flop synchronizer.
// Backpressure: none; pwr_req is a level request acknowledged by pwr_ack in ON, and pg loss while up latches FAULT.
module asic_iopwrseq #(
    parameter int NCTRL = 8,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             pwr_req,
    input  logic             iopg,
    input  logic [CW-1:0]    dly_settle,
    input  logic [CW-1:0]    dly_iso,
    output logic [NCTRL-1:0] ctrlring,
    output logic             pwr_ack,
    output logic             fault,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_WAITPG  = 3'd1,
        S_SETTLE  = 3'd2,
        S_RELEASE = 3'd3,
        S_ON      = 3'd4,
        S_DRAIN   = 3'd5,
        S_FAULT   = 3'd6,
        S_BAD     = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pg_meta_q, pg_s_q;
    logic [3:0]    ring_q, ring_d;
    logic          ack_q, ack_d;
    logic          fault_q, fault_d;
    logic          dwell_done;
    logic [CW-1:0] settle_ld, iso_ld;

    assign dwell_done = (cnt_q == CW'(1));
    assign settle_ld  = (dly_settle == '0) ? CW'(1) : dly_settle;
    assign iso_ld     = (dly_iso == '0) ? CW'(1) : dly_iso;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF:     if (pwr_req) state_d = S_WAITPG;
            S_WAITPG: begin
                if (!pwr_req)    state_d = S_OFF;
                else if (pg_s_q) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (!pwr_req)        state_d = S_OFF;
                else if (!pg_s_q)    state_d = S_WAITPG;
                else if (dwell_done) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!pg_s_q)         state_d = S_FAULT;
                else if (dwell_done) state_d = S_ON;
            end
            S_ON: begin
                if (!pg_s_q)       state_d = S_FAULT;
                else if (!pwr_req) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!pg_s_q)         state_d = S_FAULT;
                else if (dwell_done) state_d = S_OFF;
            end
            S_FAULT:   if (!pwr_req) state_d = S_OFF;
            default:   state_d = S_OFF;
        endcase
    end

    // Delays are captured only on the entry edge, so mid-dwell changes are ignored.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                S_SETTLE:           cnt_d = settle_ld;
                S_RELEASE, S_DRAIN: cnt_d = iso_ld;
                default:            cnt_d = cnt_q;
            endcase
        end else if (state_q == S_SETTLE || state_q == S_RELEASE || state_q == S_DRAIN) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Ring bits {ret, oe_en, iso_n, pwrok} decoded from the next state so they move with it.
    always_comb begin
        ring_d  = 4'b1000;
        ack_d   = 1'b0;
        fault_d = 1'b0;
        case (state_d)
            S_RELEASE: ring_d = 4'b0011;
            S_ON: begin
                ring_d = 4'b0111;
                ack_d  = 1'b1;
            end
            S_DRAIN:   ring_d = 4'b0011;
            S_FAULT:   fault_d = 1'b1;
            default:   ring_d = 4'b1000;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            pg_meta_q <= 1'b0;
            pg_s_q    <= 1'b0;
            ring_q    <= 4'b1000;
            ack_q     <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pg_meta_q <= iopg;
            pg_s_q    <= pg_meta_q;
            ring_q    <= ring_d;
            ack_q     <= ack_d;
            fault_q   <= fault_d;
        end
    end

    assign ctrlring = NCTRL'(ring_q);
    assign pwr_ack  = ack_q;
    assign fault    = fault_q;
    assign state    = state_q;

endmodule

// File: tb/tb_asic_iopwrseq.sv
// Bench for asic_iopwrseq: directed test-plan sequences plus a randomized run against a behavioural model.
module tb_asic_iopwrseq;
    localparam int NCTRL = 8;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             nreset = 1'b0;
    logic             pwr_req = 1'b0;
    logic             iopg = 1'b0;
    logic [CW-1:0]    dly_settle = '0;
    logic [CW-1:0]    dly_iso = '0;
    logic [NCTRL-1:0] ctrlring;
    logic             pwr_ack;
    logic             fault;
    logic [2:0]       state;

    int errors = 0;
    int checks = 0;

    asic_iopwrseq #(.NCTRL(NCTRL), .CW(CW)) dut (
        .clk(clk), .nreset(nreset), .pwr_req(pwr_req), .iopg(iopg),
        .dly_settle(dly_settle), .dly_iso(dly_iso),
        .ctrlring(ctrlring), .pwr_ack(pwr_ack), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural model: sync history, state number, dwell tracked as entry edge index plus duration.
    int m_s1, m_pg, m_state, m_cyc, m_tent, m_dur;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_s1 <= 0; m_pg <= 0; m_state <= 0; m_cyc <= 0; m_tent <= 0; m_dur <= 1;
        end else begin
            automatic int cur = m_cyc + 1;
            automatic int nxt = m_state;
            automatic bit done = ((cur - m_tent) == m_dur);
            automatic int n;
            case (m_state)
                0: if (pwr_req) nxt = 1;
                1: if (!pwr_req) nxt = 0; else if (m_pg == 1) nxt = 2;
                2: if (!pwr_req) nxt = 0; else if (m_pg == 0) nxt = 1; else if (done) nxt = 3;
                3: if (m_pg == 0) nxt = 6; else if (done) nxt = 4;
                4: if (m_pg == 0) nxt = 6; else if (!pwr_req) nxt = 5;
                5: if (m_pg == 0) nxt = 6; else if (done) nxt = 0;
                6: if (!pwr_req) nxt = 0;
                default: nxt = 0;
            endcase
            if (nxt != m_state && (nxt == 2 || nxt == 3 || nxt == 5)) begin
                n = (nxt == 2) ? int'(dly_settle) : int'(dly_iso);
                m_tent <= cur;
                m_dur  <= (n < 1) ? 1 : n;
            end
            m_state <= nxt;
            m_cyc   <= cur;
            m_pg    <= m_s1;
            m_s1    <= int'(iopg);
        end
    end

    function automatic int ring_of(input int s);
        case (s)
            3, 5:    return 3;
            4:       return 7;
            default: return 8;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("mdl_state", int'(state), m_state);
        chk("mdl_ring", int'(ctrlring), ring_of(m_state));
        chk("mdl_ack", int'(pwr_ack), (m_state == 4) ? 1 : 0);
        chk("mdl_fault", int'(fault), (m_state == 6) ? 1 : 0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            compare_model();
        end
    endtask

    initial begin
        nreset = 1'b0; iopg = 1'b1; dly_settle = 8'd4; dly_iso = 8'd3;
        #12;
        chk("rst_state", int'(state), 0);
        chk("rst_ring", int'(ctrlring), 8);
        chk("rst_ack", int'(pwr_ack), 0);
        chk("rst_fault", int'(fault), 0);
        @(negedge clk); nreset = 1'b1;
        step(2);

        // Power-up with D=4, I=3
        pwr_req = 1'b1;
        step(1); chk("up_e1", int'(state), 1);
        step(1); chk("up_e2", int'(state), 2);
        step(3); chk("up_e5", int'(state), 2);
        step(1); chk("up_e6", int'(state), 3); chk("up_e6_ring", int'(ctrlring), 3);
        step(2); chk("up_e8", int'(state), 3);
        step(1); chk("up_e9", int'(state), 4); chk("up_e9_ack", int'(pwr_ack), 1);
        chk("up_e9_ring", int'(ctrlring), 7);

        // Power-down
        pwr_req = 1'b0;
        step(1); chk("dn_ring", int'(ctrlring), 3); chk("dn_ack", int'(pwr_ack), 0);
        chk("dn_state", int'(state), 5);
        step(2); chk("dn_e3", int'(state), 5);
        step(1); chk("dn_off", int'(state), 0); chk("dn_off_ring", int'(ctrlring), 8);

        // pg glitch during SETTLE restarts the dwell
        pwr_req = 1'b1;
        step(2); chk("gl_settle", int'(state), 2);
        iopg = 1'b0;
        step(3); chk("gl_waitpg", int'(state), 1);
        iopg = 1'b1;
        step(2); chk("gl_still_wait", int'(state), 1);
        step(1); chk("gl_resettle", int'(state), 2);
        step(3); chk("gl_dwell", int'(state), 2);
        step(1); chk("gl_release", int'(state), 3);
        step(3); chk("gl_on", int'(state), 4);

        // pg loss in ON -> sticky FAULT
        iopg = 1'b0;
        step(2); chk("ft_pre", int'(state), 4);
        step(1); chk("ft_state", int'(state), 6); chk("ft_fault", int'(fault), 1);
        chk("ft_ring", int'(ctrlring), 8);
        step(5); chk("ft_hold", int'(fault), 1);
        pwr_req = 1'b0;
        step(1); chk("ft_clr_state", int'(state), 0); chk("ft_clr", int'(fault), 0);

        // Zero delays -> one-cycle dwells
        iopg = 1'b1; dly_settle = 8'd0; dly_iso = 8'd0;
        step(3);
        pwr_req = 1'b1;
        step(3); chk("z_release", int'(state), 3);
        step(1); chk("z_on", int'(state), 4);
        pwr_req = 1'b0;
        step(1); chk("z_drain", int'(state), 5);
        step(1); chk("z_off", int'(state), 0);

        // Async reset while in RELEASE
        dly_settle = 8'd4; dly_iso = 8'd3; pwr_req = 1'b1;
        step(6); chk("ar_pre", int'(state), 3);
        #2 nreset = 1'b0;
        #1;
        chk("ar_state", int'(state), 0); chk("ar_ring", int'(ctrlring), 8);
        chk("ar_ack", int'(pwr_ack), 0);
        pwr_req = 1'b0;
        step(1); nreset = 1'b1;
        step(3); chk("ar_off", int'(state), 0);

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            step(1);
            if (!nreset) nreset = 1'b1;
            else if ($urandom_range(0, 499) == 0) nreset = 1'b0;
            if ($urandom_range(0, 19) == 0) pwr_req = ~pwr_req;
            if ($urandom_range(0, 39) == 0) iopg = ~iopg;
            else if (!iopg && $urandom_range(0, 7) == 0) iopg = 1'b1;
            if ($urandom_range(0, 9) == 0) dly_settle = CW'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) dly_iso = CW'($urandom_range(0, 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
